spi_slave_out: RTL and testbench
================================

# spi_slave_out

SPI slave transmitter: returns data to the master on MISO while the master holds chip select low. It is the reverse-direction companion to the existing master-transmit/slave-receive SPI pair. It uses the same framing: system-clocked, one bit per `clock` edge, MSB first, no separate SCK. A one-word holding register with a ready/strobe handshake lets the core queue the next reply while the current frame shifts.

## Interface
- `WIDTH`, 16: frame length in bits and data width.
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `data`  in  WIDTH  word to transmit; sampled when `writeSPI` is high.
- `writeSPI`  in  1  load strobe, one cycle.
- `ready`  out  1  holding register empty; a `writeSPI` is accepted.
- `slaveChipSelectN`  in  1  frame enable from master, active low.
- `MISO`  out  1  serial data, registered.
- `txDone`  out  1  one-cycle pulse after the last bit of a full frame.
- `underrun`  out  1  one-cycle pulse: frame started with holding register empty.
- `overrun`  out  1  one-cycle pulse: `writeSPI` dropped because holding was full.
- `aborted`  out  1  one-cycle pulse: chip select deasserted mid-frame.

## Operation
- Storage:
  - holding register `hold[WIDTH-1:0]` with `holdValid`;
  - shifter `shift[WIDTH-1:0]`;
  - bit counter `count`, $clog2(WIDTH+1) bits.
- `ready` = !`holdValid` (combinational from the register).
- Write accept rule: `writeSPI` is accepted if `holdValid`=0, or if `hold` is being consumed by a frame start on the same edge. An accepted write loads `hold`=`data` and sets `holdValid`=1. Otherwise the write is dropped and `overrun` pulses.
- States: IDLE, SHIFT, WAIT_HIGH.
  - IDLE, edge with `slaveChipSelectN`=0, starting the frame:
    - if `holdValid`: `shift`<=`hold`, clear `holdValid`;
    - else: `shift`<=0 and `underrun` pulses.
    - In both cases: `MISO`<=bit WIDTH-1 of the loaded word, `count`<=1, go to SHIFT.
  - SHIFT, csN=0, `count`<WIDTH: shift left, `MISO`<=next bit, `count`+1.
  - SHIFT, csN=0, `count`=WIDTH: `txDone` pulses, `MISO`<=0, go to WAIT_HIGH.
  - SHIFT, csN=1: `aborted` pulses, `MISO`<=0, go to IDLE. The word is consumed, not retried.
  - WAIT_HIGH: stay until csN=1, then go to IDLE. `MISO` holds 0. A held-low chip select never starts a second frame.
- `MISO` is 0 whenever not in SHIFT.
- Reset values: state IDLE, `holdValid`=0 (`ready`=1), `shift`=0, `count`=0, `MISO`=0, all pulses 0.
- Reset mid-frame drops both the frame and the holding register immediately, asynchronously.

## Timing
- Frame-start edge = first edge sampling csN=0 in IDLE. Bit WIDTH-1 appears on `MISO` after that edge.
- Bit WIDTH-1-k is valid from frame-start edge + k to edge + k+1, for k = 0..WIDTH-1.
- `txDone` is high for the one cycle following edge + WIDTH.
- A master sampling MISO on edges +1..+WIDTH receives the word MSB first.
- Back-to-back frames: csN must be high for at least one sampled edge between frames. Minimum frame period is WIDTH+2 cycles.
- `ready` rises the cycle after the frame-start edge when `hold` is consumed. It falls the cycle after an accepted write.
- Same-edge write and frame start with `holdValid`=0: the frame sends 0 with `underrun`, and the write lands in `hold` for the next frame.

## Structure
- Shared SPI package/header: `WIDTH` default 16, state encodings, and a frame-gap constant of 1. The existing SPI modules use these too.
- Natural split: sub-module `spi_hold_reg` for the holding register, accept/overrun logic and `ready`. The shifter FSM stays in `spi_slave_out`.

## Test plan
- Reset check: after `reset` pulse, `ready`=1, `MISO`=0, no pulses. Write 16'h5055, drop csN for 17 cycles -> MISO serial 0101_0000_0101_0101, `txDone` at cycle 17, `ready`=1 again.
- Back-to-back frames: write 16'hD655, start frame; during shift write 16'h1255 -> accepted. Raise csN one cycle, lower again -> second frame carries 16'h1255.
- Overrun: with `hold` full and no frame active, write 16'hAAAA -> `overrun` pulses, next frame still sends the earlier word.
- Underrun: drop csN with `ready`=1 -> 16 zero bits, `underrun` pulse at frame start, `txDone` at end.
- Abort: raise csN after 5 bits of 16'hFFFF -> `aborted` pulse, `MISO`=0, no `txDone`. The next frame sends the next written word.
- Mid-frame reset: assert `reset` asynchronously at bit 8 -> `MISO`=0 and `ready`=1 immediately. After release with csN still low, a new frame starts with `underrun`.

Source files
------------

// File: rtl/spi_slave_out_pkg.sv
// Shared SPI definitions: default frame width, frame gap and shifter state encodings.
// Used by both the slave transmitter and the master-transmit/slave-receive pair.
package spi_slave_out_pkg;

  localparam int SPI_WIDTH     = 16;
  localparam int SPI_FRAME_GAP = 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SHIFT     = 2'd1,
    ST_WAIT_HIGH = 2'd2
  } spi_state_t;

endpackage

// File: rtl/spi_hold_reg.sv
// One-word holding register in front of the SPI shifter; write lands one cycle after the strobe.
// ready = register empty; a write while full is dropped and flagged with a registered overrun pulse.
module spi_hold_reg
  import spi_slave_out_pkg::*;
#(
  parameter int WIDTH = SPI_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic             write_vld,
  input  logic             consume,
  output logic [WIDTH-1:0] hold_dat,
  output logic             hold_vld,
  output logic             ready,
  output logic             overrun
);

  logic accept;

  // A frame start that drains the register on this edge frees it for a same-edge write.
  assign accept = write_vld && (!hold_vld || consume);
  assign ready  = !hold_vld;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_dat <= '0;
      hold_vld <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= write_vld && !accept;
      if (accept) begin
        hold_dat <= data;
        hold_vld <= 1'b1;
      end else if (consume) begin
        hold_vld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spi_slave_out.sv
// SPI slave transmitter: shifts a held word out on MISO, MSB first, one bit per clock while csN is low.
// MSB appears after the frame-start edge; the holding register lets the core queue the next reply.
module spi_slave_out
  import spi_slave_out_pkg::*;
#(
  parameter int WIDTH = SPI_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic             writeSPI,
  output logic             ready,
  input  logic             slaveChipSelectN,
  output logic             MISO,
  output logic             txDone,
  output logic             underrun,
  output logic             overrun,
  output logic             aborted
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  spi_state_t       state, state_nxt;
  logic [WIDTH-1:0] shift_dat, shift_nxt;
  logic [WIDTH-1:0] hold_dat;
  logic [CW-1:0]    count, count_nxt;
  logic             hold_vld;
  logic             consume;
  logic             miso_nxt, txdone_nxt, underrun_nxt, aborted_nxt;

  spi_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clock     (clock),
    .reset     (reset),
    .data      (data),
    .write_vld (writeSPI),
    .consume   (consume),
    .hold_dat  (hold_dat),
    .hold_vld  (hold_vld),
    .ready     (ready),
    .overrun   (overrun)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      shift_dat <= '0;
      count     <= '0;
      MISO      <= 1'b0;
      txDone    <= 1'b0;
      underrun  <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_dat <= shift_nxt;
      count     <= count_nxt;
      MISO      <= miso_nxt;
      txDone    <= txdone_nxt;
      underrun  <= underrun_nxt;
      aborted   <= aborted_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    shift_nxt    = shift_dat;
    count_nxt    = count;
    miso_nxt     = 1'b0;
    txdone_nxt   = 1'b0;
    underrun_nxt = 1'b0;
    aborted_nxt  = 1'b0;
    consume      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!slaveChipSelectN) begin
          // An empty holding register still runs a full frame, of zeros.
          consume      = hold_vld;
          shift_nxt    = hold_vld ? hold_dat : '0;
          underrun_nxt = !hold_vld;
          miso_nxt     = shift_nxt[WIDTH-1];
          count_nxt    = CW'(1);
          state_nxt    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (slaveChipSelectN) begin
          aborted_nxt = 1'b1;
          count_nxt   = '0;
          state_nxt   = ST_IDLE;
        end else if (count == LAST) begin
          txdone_nxt = 1'b1;
          state_nxt  = ST_WAIT_HIGH;
        end else begin
          shift_nxt = {shift_dat[WIDTH-2:0], 1'b0};
          miso_nxt  = shift_nxt[WIDTH-1];
          count_nxt = count + CW'(1);
        end
      end
      ST_WAIT_HIGH: begin
        // A chip select held low after a full frame must not retrigger.
        if (slaveChipSelectN) begin
          count_nxt = '0;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_slave_out.sv
// Directed bench for spi_slave_out: framing, handshake, overrun/underrun, abort and async reset.
module tb_spi_slave_out;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] data;
  logic        writeSPI;
  logic        ready;
  logic        slaveChipSelectN;
  logic        MISO;
  logic        txDone;
  logic        underrun;
  logic        overrun;
  logic        aborted;

  int total = 0;
  int bad   = 0;

  spi_slave_out dut (
    .clock            (clock),
    .reset            (reset),
    .data             (data),
    .writeSPI         (writeSPI),
    .ready            (ready),
    .slaveChipSelectN (slaveChipSelectN),
    .MISO             (MISO),
    .txDone           (txDone),
    .underrun         (underrun),
    .overrun          (overrun),
    .aborted          (aborted)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic write_word(input logic [15:0] d);
    data     = d;
    writeSPI = 1'b1;
    tick();
    writeSPI = 1'b0;
  endtask

  // Runs one full frame, optionally writing wr_dat on edge frame-start+wr_at.
  task automatic frame(input string tag, input logic [15:0] exp, input logic exp_under,
                       input logic exp_rdy0, input bit wr_en, input int wr_at,
                       input logic [15:0] wr_dat);
    logic [15:0] rx;
    logic        und, rdy0, early, ov;
    rx = '0; und = 0; rdy0 = 0; early = 0; ov = 0;
    slaveChipSelectN = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (wr_en && k == wr_at) begin
        data     = wr_dat;
        writeSPI = 1'b1;
      end
      tick();
      writeSPI  = 1'b0;
      rx[15-k]  = MISO;
      early     = early | txDone;
      if (k == 0) begin
        und  = underrun;
        rdy0 = ready;
      end
      if (wr_en && k == wr_at) ov = overrun;
    end
    tick();
    chk({tag, ".data"}, 32'(rx), 32'(exp));
    chk({tag, ".underrun"}, 32'(und), 32'(exp_under));
    chk({tag, ".ready_start"}, 32'(rdy0), 32'(exp_rdy0));
    chk({tag, ".txdone_early"}, 32'(early), 32'd0);
    chk({tag, ".txdone"}, 32'(txDone), 32'd1);
    chk({tag, ".miso_end"}, 32'(MISO), 32'd0);
    if (wr_en) chk({tag, ".wr_overrun"}, 32'(ov), 32'd0);
    slaveChipSelectN = 1'b1;
    tick();
  endtask

  initial begin
    logic [4:0] ones;
    reset = 1'b1; data = '0; writeSPI = 1'b0; slaveChipSelectN = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst.ready", 32'(ready), 32'd1);
    chk("rst.miso", 32'(MISO), 32'd0);
    chk("rst.pulses", {28'd0, txDone, underrun, overrun, aborted}, 32'd0);

    // Basic frame
    write_word(16'h5055);
    chk("w1.ready", 32'(ready), 32'd0);
    frame("f1", 16'h5055, 1'b0, 1'b1, 1'b0, 0, 16'h0);
    chk("f1.ready_after", 32'(ready), 32'd1);

    // Back-to-back frames with a mid-frame queued write
    write_word(16'hD655);
    frame("b2b1", 16'hD655, 1'b0, 1'b1, 1'b1, 5, 16'h1255);
    chk("b2b.ready_full", 32'(ready), 32'd0);
    frame("b2b2", 16'h1255, 1'b0, 1'b1, 1'b0, 0, 16'h0);

    // Overrun: second write while full is dropped
    write_word(16'h3C3C);
    chk("ov.first", 32'(overrun), 32'd0);
    write_word(16'hAAAA);
    chk("ov.pulse", 32'(overrun), 32'd1);
    tick();
    chk("ov.clear", 32'(overrun), 32'd0);
    frame("ov", 16'h3C3C, 1'b0, 1'b1, 1'b0, 0, 16'h0);

    // Underrun
    frame("un", 16'h0000, 1'b1, 1'b1, 1'b0, 0, 16'h0);

    // Abort after five bits
    write_word(16'hFFFF);
    slaveChipSelectN = 1'b0;
    ones = '0;
    for (int k = 0; k < 5; k++) begin
      tick();
      ones = ones + 5'(MISO);
    end
    chk("ab.bits", 32'(ones), 32'd5);
    slaveChipSelectN = 1'b1;
    tick();
    chk("ab.pulse", 32'(aborted), 32'd1);
    chk("ab.miso", 32'(MISO), 32'd0);
    chk("ab.txdone", 32'(txDone), 32'd0);
    chk("ab.ready", 32'(ready), 32'd1);
    tick();
    chk("ab.clear", 32'(aborted), 32'd0);
    write_word(16'h1234);
    frame("ab.next", 16'h1234, 1'b0, 1'b1, 1'b0, 0, 16'h0);

    // Same-edge write and frame start with empty register
    frame("same", 16'h0000, 1'b1, 1'b0, 1'b1, 0, 16'h7E81);
    frame("same.next", 16'h7E81, 1'b0, 1'b1, 1'b0, 0, 16'h0);

    // Asynchronous reset mid-frame with a queued word
    write_word(16'hA5A5);
    slaveChipSelectN = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) begin
        data     = 16'h5A5A;
        writeSPI = 1'b1;
      end
      tick();
      writeSPI = 1'b0;
    end
    chk("mr.bit8", 32'(MISO), 32'd1);
    chk("mr.full", 32'(ready), 32'd0);
    #1 reset = 1'b1;
    #1;
    chk("mr.miso", 32'(MISO), 32'd0);
    chk("mr.ready", 32'(ready), 32'd1);
    reset = 1'b0;
    tick();
    chk("mr.underrun", 32'(underrun), 32'd1);
    chk("mr.start_miso", 32'(MISO), 32'd0);
    for (int k = 1; k < 16; k++) tick();
    chk("mr.txdone_early", 32'(txDone), 32'd0);
    tick();
    chk("mr.txdone", 32'(txDone), 32'd1);
    slaveChipSelectN = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
